// File: rtl/logic_arb_pkg.sv
// Shared constants for the logic-unit arbiter: function codes, FSM state encoding
// and the error threshold on captured function codes.
package logic_arb_pkg;

  localparam int DATA_W = 32;
  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] FN_AND = 3'b000;
  localparam logic [FUNC_W-1:0] FN_OR  = 3'b001;
  localparam logic [FUNC_W-1:0] FN_XOR = 3'b010;
  localparam logic [FUNC_W-1:0] FN_NOR = 3'b011;
  localparam logic [FUNC_W-1:0] FN_NOT = 3'b100;

  // Codes above this one are reserved: the unit returns 0 and the response is flagged.
  localparam logic [FUNC_W-1:0] FN_MAX_VALID = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic func_is_err(input logic [FUNC_W-1:0] f);
    return f > FN_MAX_VALID;
  endfunction

endpackage

// File: rtl/logic_unit.sv
// Shared 32-bit combinational logic unit: AND, OR, XOR, NOR, NOT(a); reserved codes yield 0.
module logic_unit
  import logic_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FUNC_W-1:0] func_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (func_i)
      FN_AND:  y_o = a_i & b_i;
      FN_OR:   y_o = a_i | b_i;
      FN_XOR:  y_o = a_i ^ b_i;
      FN_NOR:  y_o = ~(a_i | b_i);
      FN_NOT:  y_o = ~a_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above ptr_i, wrapping
// at NREQ. Reusable wherever a rotating-priority one-hot grant is needed.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  assign any_o = |req_i;

  always_comb begin
    logic [PW:0] j;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit keeps ptr+k from overflowing before the wrap subtraction.
      j = {1'b0, ptr_i} + (PW+1)'(k);
      if (j >= (PW+1)'(NREQ)) begin
        j = j - (PW+1)'(NREQ);
      end
      if (!found && req_i[j[PW-1:0]]) begin
        found              = 1'b1;
        grant_o[j[PW-1:0]] = 1'b1;
        idx_o              = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin front end sharing one logic unit among NREQ requesters, with a single tagged
// response channel. Optional macro LOGIC_ARB_BACK2BACK_EN lets RESP accept the next request.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*FUNC_W-1:0] req_func,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_d;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [FUNC_W-1:0]   func_q;
  logic [PW-1:0]       id_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [IDW-1:0]      resp_id_q;
  logic                resp_err_q;

  logic [DATA_W-1:0]   a_arr    [NREQ];
  logic [DATA_W-1:0]   b_arr    [NREQ];
  logic [FUNC_W-1:0]   func_arr [NREQ];
  logic [NREQ-1:0]     grant;
  logic [PW-1:0]       gidx;
  logic                gany;
  logic                arb_open;
  logic                xfer;
  logic [DATA_W-1:0]   lu_y;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]    = req_b[DATA_W*gi +: DATA_W];
      assign func_arr[gi] = req_func[FUNC_W*gi +: FUNC_W];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

`ifdef LOGIC_ARB_BACK2BACK_EN
  // A response leaving this cycle frees the unit, so arbitration may overlap it.
  assign arb_open = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
`else
  assign arb_open = (state_q == IDLE);
`endif

  assign req_ready = (rst_n && arb_open) ? grant : '0;
  assign xfer      = rst_n && arb_open && gany;
  assign ptr_d     = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);

  logic_unit u_logic_unit (
    .a_i    (a_q),
    .b_i    (b_q),
    .func_i (func_q),
    .y_o    (lu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            a_q     <= a_arr[gidx];
            b_q     <= b_arr[gidx];
            func_q  <= func_arr[gidx];
            id_q    <= gidx;
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= lu_y;
          resp_err_q   <= func_is_err(func_q);
          resp_id_q    <= IDW'(id_q);
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
`ifdef LOGIC_ARB_BACK2BACK_EN
            if (xfer) begin
              a_q     <= a_arr[gidx];
              b_q     <= b_arr[gidx];
              func_q  <= func_arr[gidx];
              id_q    <= gidx;
              ptr_q   <= ptr_d;
              state_q <= EXEC;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;

  // Requesters must hold valid and operands steady until they see ready.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_hold_chk
      a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid[gi] && !req_ready[gi]) |=>
          (req_valid[gi] && $stable(req_a[DATA_W*gi +: DATA_W]) &&
           $stable(req_b[DATA_W*gi +: DATA_W]) && $stable(req_func[FUNC_W*gi +: FUNC_W])));
    end
  endgenerate

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a driver issues directed ops and queues the
// hand-computed responses; an independent monitor pops and checks each response handshake.
module tb_logic_unit_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef LOGIC_ARB_BACK2BACK_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_func = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic              resp_err;

  logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_func   (req_func),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] exp;
    logic        err;
  } op_t;

  typedef struct {
    logic [31:0] data;
    int          id;
    logic        err;
    int          acc;
  } exp_t;

  op_t  ops[$];
  exp_t sb[$];
  int   grants[$];
  int   hs[$];
  int   exp_g[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [31:0] exp, input logic err);
    op_t o;
    o.req = r; o.a = a; o.b = b; o.f = f; o.exp = exp; o.err = err;
    ops.push_back(o);
  endtask

  function automatic int head(input int r);
    for (int k = 0; k < ops.size(); k++) begin
      if (ops[k].req == r) return k;
    end
    return -1;
  endfunction

  task automatic check_grants(input string name);
    check({name, "_count"}, 32'(grants.size()), 32'(exp_g.size()));
    for (int k = 0; k < exp_g.size(); k++) begin
      check($sformatf("%s_%0d", name, k),
            (k < grants.size()) ? 32'(grants[k]) : 32'hFFFF_FFFF, 32'(exp_g[k]));
    end
  endtask

  // Drive queued ops until every op is accepted and every response retired.
  task automatic run_ops(input int bp_cycles, input int limit);
    int bp_seen;
    int n;
    int k;
    exp_t e;
    bp_seen = 0;
    n = 0;
    resp_ready = (bp_cycles == 0);
    while ((ops.size() > 0 || sb.size() > 0) && n < limit) begin
      @(posedge clk); #1;
      if (bp_seen >= bp_cycles) resp_ready = 1'b1;
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        k = head(i);
        if (k >= 0) begin
          req_valid[i]        = 1'b1;
          req_a[32*i +: 32]   = ops[k].a;
          req_b[32*i +: 32]   = ops[k].b;
          req_func[3*i +: 3]  = ops[k].f;
        end
      end
      @(negedge clk);
      if (resp_valid && !resp_ready) bp_seen++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          k = head(i);
          e.data = ops[k].exp; e.id = i; e.err = ops[k].err; e.acc = cyc;
          sb.push_back(e);
          grants.push_back(i);
          $display("[TB] cyc %0d accept req %0d func %b", cyc, i, ops[k].f);
          ops.delete(k);
        end
      end
      n++;
    end
    if (n >= limit) begin
      tests++; fails++;
      $display("FAIL run_ops_timeout: got %0d ops/%0d resps outstanding, expected 0", ops.size(), sb.size());
      ops.delete();
      sb.delete();
    end
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Monitor: checks grant legality every cycle and each response at its handshake.
  initial begin
    bit          in_resp;
    int          start;
    logic [31:0] hold_d;
    logic [IDW-1:0] hold_id;
    logic        hold_err;
    exp_t        e;
    in_resp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 0;
      end else begin
        check("ready_onehot",
              32'(((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)), 32'd0);
        if (resp_valid) begin
          if (!in_resp) begin
            in_resp = 1; start = cyc;
            hold_d = resp_data; hold_id = resp_id; hold_err = resp_err;
          end else begin
            check("resp_stable", {resp_data ^ hold_d} | 32'(resp_id ^ hold_id) | 32'(resp_err ^ hold_err), 32'd0);
          end
          if (!resp_ready) begin
            check("ready_in_stall", 32'(req_ready), 32'd0);
          end else begin
            if (sb.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_resp: got id %0d data %h, expected none", resp_id, resp_data);
            end else begin
              e = sb.pop_front();
              $display("[TB] cyc %0d resp id %0d data %h err %b", cyc, resp_id, resp_data, resp_err);
              check("resp_data", resp_data, e.data);
              check("resp_id", 32'(resp_id), 32'(e.id));
              check("resp_err", 32'(resp_err), 32'(e.err));
              check("resp_latency", 32'(start - e.acc), 32'd2);
            end
            hs.push_back(cyc);
            in_resp = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with all requesters shouting
    rst_n = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;

    // Single AND request from requester 0
    grants.delete();
    add_op(0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0);
    run_ops(0, 50);
    exp_g = {0};
    check_grants("single_grant");

    // All four valid: OR, XOR, NOR, NOT, then requester 0 again
    reset_dut();
    grants.delete();
    add_op(0, 32'h12345678, 32'h0000FFFF, 3'b001, 32'h1234FFFF, 1'b0);
    add_op(1, 32'h12345678, 32'h0000FFFF, 3'b010, 32'h1234A987, 1'b0);
    add_op(2, 32'h12345678, 32'h0000FFFF, 3'b011, 32'hEDCB0000, 1'b0);
    add_op(3, 32'h12345678, 32'h0000FFFF, 3'b100, 32'hEDCBA987, 1'b0);
    add_op(0, 32'h12345678, 32'h0000FFFF, 3'b000, 32'h00005678, 1'b0);
    run_ops(0, 100);
    exp_g = {0, 1, 2, 3, 0};
    check_grants("rr_grant");

    // Backpressure: five stalled response cycles
    grants.delete();
    add_op(1, 32'hFFFF0000, 32'h12345678, 3'b000, 32'h12340000, 1'b0);
    run_ops(5, 50);
    exp_g = {1};
    check_grants("bp_grant");

    // Reserved function code
    grants.delete();
    add_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'h00000000, 1'b1);
    run_ops(0, 50);
    exp_g = {2};
    check_grants("err_grant");

    // Reset while the accepted op is in EXEC; pointer would otherwise favour requester 3
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'hFFFFFFFF;
    req_b[64 +: 32] = 32'hFFFFFFFF;
    req_func[6 +: 3] = 3'b000;
    @(negedge clk);
    check("midrst_accept", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    check("midrst_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_id", 32'(resp_id), 32'd0);
    check("midrst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;
    sb.delete();
    grants.delete();
    add_op(1, 32'h0000FFFF, 32'hFFFFFFFF, 3'b000, 32'h0000FFFF, 1'b0);
    add_op(3, 32'h0F000000, 32'h000000F0, 3'b001, 32'h0F0000F0, 1'b0);
    run_ops(0, 50);
    exp_g = {1, 3};
    check_grants("midrst_grant");

    // Two requesters continuously valid: response spacing
    grants.delete();
    hs.delete();
    add_op(0, 32'hAAAAAAAA, 32'hFFFF0000, 3'b000, 32'hAAAA0000, 1'b0);
    add_op(0, 32'hAAAAAAAA, 32'hFFFFFFFF, 3'b010, 32'h55555555, 1'b0);
    add_op(0, 32'h00000000, 32'h12345678, 3'b100, 32'hFFFFFFFF, 1'b0);
    add_op(2, 32'h00000001, 32'h80000000, 3'b001, 32'h80000001, 1'b0);
    add_op(2, 32'h00000000, 32'h00000000, 3'b011, 32'hFFFFFFFF, 1'b0);
    add_op(2, 32'h13572468, 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
    run_ops(0, 100);
    exp_g = {0, 2, 0, 2, 0, 2};
    check_grants("tput_grant");
    check("tput_count", 32'(hs.size()), 32'd6);
    for (int k = 1; k < hs.size(); k++) begin
      check($sformatf("tput_gap_%0d", k), 32'(hs[k] - hs[k-1]), 32'(PERIOD));
    end

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares a single instance of the existing 32-bit logic unit between NREQ requesters (e.g. decode stage, branch-compare helper, debug port).
- Round-robin arbitration, valid/ready handshake on each request port, and one registered response channel tagged with the requester index.
- The shared unit uses func 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NOT; codes 101–111 produce 0.
- Sits between the requesting pipeline blocks and the shared logic datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of resp_id; must be at least clog2(NREQ)

Ports:
- clk  input  1  single system clock; everything is on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_a  input  NREQ*32  operand A, requester i in bits [32i+31:32i]
- req_b  input  NREQ*32  operand B, same packing as req_a
- req_func  input  NREQ*3  function code, requester i in bits [3i+2:3i]
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_data  output  32  logic unit result
- resp_id  output  IDW  index of the requester that was served
- resp_err  output  1  high when the captured func was 101..111 (resp_data is then 0)

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, all captured operands cleared.
  - req_ready is all-zero while rst_n is low.
  - Reset mid-operation discards any in-flight request and any pending response, with no handshake completion.
- States:
  - IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant g = first i with req_valid[i] searching from rr_ptr upward, wrapping at NREQ.
  - req_ready[g]=1 combinationally in the same cycle. A transfer completes when req_valid[g] && req_ready[g].
  - On transfer: capture a, b, func and g; rr_ptr <= (g+1) mod NREQ; go to EXEC.
  - No valid request: stay in IDLE; rr_ptr is unchanged.
- EXEC:
  - Captured operands drive the logic unit.
  - resp_data/resp_err/resp_id are registered at the end of the cycle; resp_valid <= 1; go to RESP.
  - req_ready is all-zero.
- RESP:
  - resp_valid held high; resp_data, resp_id and resp_err held stable until resp_ready is sampled high.
  - On resp_valid && resp_ready: resp_valid <= 0, go to IDLE.
  - req_ready is all-zero unless the optional feature is enabled.
- Timing:
  - Latency from request accept to resp_valid is 2 cycles.
  - Throughput is 1 op per 3 cycles with resp_ready tied high.
- Fairness:
  - A requester holding valid high is served within NREQ grants.
  - Requesters must hold req_valid and operands stable until req_ready is seen; this is asserted in simulation only.
- Widths: resp_id is zero-extended from the grant index; the result is the full 32 bits with no truncation.

Optional Feature:
- Macro: LOGIC_ARB_BACK2BACK_EN.
- Defined:
  - In RESP, when resp_ready=1 in a cycle, arbitration runs in that same cycle; req_ready[g] may be asserted, and on transfer the next state is EXEC rather than IDLE.
  - rr_ptr updates as in IDLE.
  - Throughput becomes 1 op per 2 cycles.
- Undefined:
  - RESP always returns to IDLE, giving 3 cycles per op.
  - The extra arbitration logic is not present.

Decomposition:
- Package logic_arb_pkg:
  - func code localparams (FN_AND=3'b000 … FN_NOT=3'b100).
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - the FN_MAX_VALID=3'b100 constant used for resp_err.
- Sub-module rr_arbiter (NREQ param; inputs req, ptr; outputs onehot grant and encoded index). It is purely combinational and is reusable for the register-file port arbiter.
- The logic unit is instantiated once inside logic_unit_arbiter.

Test Plan:
- Reset, then a single request:
  - Stimulus: req 0 with a=F0F0F0F0, b=0FF00FF0, func=000.
  - Required: req_ready[0] in the accept cycle; 2 cycles later resp_valid=1, resp_data=00F000F0, resp_id=0, resp_err=0.
- All 4 requesters valid continuously, with func 001/010/011/100 on a=12345678, b=0000FFFF, and resp_ready=1:
  - Grant order 0,1,2,3,0.
  - Results 1234FFFF, 1234A987, EDCB0000, EDCBA987.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles while in RESP.
  - Required: resp_valid, resp_data and resp_id stay stable; req_ready stays 0; the handshake completes when resp_ready=1.
- Invalid func 101 from req 2:
  - Required: resp_data=00000000, resp_err=1, resp_id=2.
- Reset mid-operation:
  - Stimulus: rst_n low during EXEC.
  - Required: next cycle resp_valid=0 and state IDLE; rr_ptr=0, so a subsequent request from req 1 and req 3 grants 1 first.
- LOGIC_ARB_BACK2BACK_EN defined, two requesters always valid, resp_ready=1:
  - Required: resp_valid pulses every 2 cycles.
  - Without the macro, every 3 cycles.
